text_writer: RTL and testbench



---
 rtl/text_writer_pkg.sv | 33 +++
 rtl/text_writer_if.sv | 38 +++
 rtl/text_writer.sv | 205 ++++++++++++++++++++
 tb/tb_text_writer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/text_writer_pkg.sv
// ----------------------------------------------------------------------------
// text_pkg
// Shared definitions for the text-mode writer and the display side:
//   - default screen geometry (COLS_DEF x ROWS_DEF) and clear character
//   - control-code byte values understood by the writer
//   - writer state encoding
//   - pack_addr(): builds the {row[4:0], col[6:0]} RAM address
// Optional feature macro used by the writer: TEXT_WRITER_TAB_EN.
// ----------------------------------------------------------------------------
package text_pkg;

    localparam int         COLS_DEF  = 80;
    localparam int         ROWS_DEF  = 25;
    localparam logic [7:0] BLANK_DEF = 8'h20;

    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_TAB = 8'h09;
    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_CR  = 8'h0D;

    typedef enum logic [1:0] {
        CLR_ALL = 2'd0,
        IDLE    = 2'd1,
        CLR_ROW = 2'd2
    } state_t;

    // Row in the upper bits so a row occupies a contiguous 128-entry block.
    function automatic logic [11:0] pack_addr(input logic [4:0] row, input logic [6:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/text_writer_if.sv
// ----------------------------------------------------------------------------
// text_writer_if
// Groups the byte-stream handshake and the screen/colour RAM write bus.
//   in_data/in_valid/in_ready : byte stream into the writer
//   attr                      : colour attribute for every write
//   wr_addr/wr_char/wr_colr   : RAM write address and data
//   wren_ms/wren_mc           : screen / colour RAM write enables
//   cursor_x/cursor_y         : current cursor position
//   busy                      : writer is clearing
// modport master : byte producer side
// modport slave  : the writer itself
// ----------------------------------------------------------------------------
interface text_writer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  attr;
    logic [11:0] wr_addr;
    logic [7:0]  wr_char;
    logic [7:0]  wr_colr;
    logic        wren_ms;
    logic        wren_mc;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    modport master (
        output in_data, in_valid, attr,
        input  in_ready, wr_addr, wr_char, wr_colr, wren_ms, wren_mc,
               cursor_x, cursor_y, busy
    );

    modport slave (
        input  in_data, in_valid, attr,
        output in_ready, wr_addr, wr_char, wr_colr, wren_ms, wren_mc,
               cursor_x, cursor_y, busy
    );
endinterface

// File: rtl/text_writer.sv
// ----------------------------------------------------------------------------
// text_writer
// Feeds an 80x25 text-mode display: accepts bytes over valid/ready, decodes
// BS/LF/CR/FF (and TAB when TEXT_WRITER_TAB_EN is defined), tracks the cursor
// and issues one registered write per cycle to the screen and colour RAMs.
// After reset and on FF the whole screen is blanked; every row advance blanks
// the new row before more bytes are taken.
//
// Ports:
//   clk    : RAM-side clock
//   rst    : synchronous active-high reset (restarts the full clear)
//   io_bus : text_writer_if.slave (stream in, RAM write bus, cursor, busy)
//
// Optional feature: define TEXT_WRITER_TAB_EN to make 0x09 a tab stop every
// 8 columns; otherwise 0x09 is written like any printable byte.
// ----------------------------------------------------------------------------
module text_writer
    import text_pkg::*;
#(
    parameter int         COLS  = COLS_DEF,
    parameter int         ROWS  = ROWS_DEF,
    parameter logic [7:0] BLANK = BLANK_DEF
) (
    input  logic         clk,
    input  logic         rst,
    text_writer_if.slave io_bus
);

    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

    state_t      r_state;
    logic [6:0]  r_col;
    logic [4:0]  r_row;
    logic [6:0]  r_clr_col;
    logic [4:0]  r_clr_row;
    logic [11:0] r_wr_addr;
    logic [7:0]  r_wr_char;
    logic [7:0]  r_wr_colr;
    logic        r_wren;
    logic        r_in_ready;

    logic       w_accept;
    logic [4:0] w_row_next;

    assign w_accept   = io_bus.in_valid && r_in_ready;
    assign w_row_next = (r_row == ROW_LAST) ? 5'd0 : r_row + 5'd1;

`ifdef TEXT_WRITER_TAB_EN
    // Next multiple of 8, one bit wider than the column so overflow past
    // COLS (up to 128) is visible.
    logic [7:0] w_tab_col;
    logic       w_tab_wrap;
    assign w_tab_col  = {({1'b0, r_col[6:3]} + 5'd1), 3'b000};
    assign w_tab_wrap = (w_tab_col >= 8'(COLS));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CLR_ALL;
            r_col      <= '0;
            r_row      <= '0;
            r_clr_col  <= '0;
            r_clr_row  <= '0;
            r_wr_addr  <= '0;
            r_wr_char  <= '0;
            r_wr_colr  <= '0;
            r_wren     <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            case (r_state)
                CLR_ALL: begin
                    r_wren    <= 1'b1;
                    r_wr_addr <= pack_addr(r_clr_row, r_clr_col);
                    r_wr_char <= BLANK;
                    r_wr_colr <= io_bus.attr;
                    if (r_clr_col == COL_LAST) begin
                        r_clr_col <= '0;
                        if (r_clr_row == ROW_LAST) begin
                            r_clr_row <= '0;
                            r_state   <= IDLE;
                        end else begin
                            r_clr_row <= r_clr_row + 5'd1;
                        end
                    end else begin
                        r_clr_col <= r_clr_col + 7'd1;
                    end
                end

                CLR_ROW: begin
                    // The cursor row is already the row being cleared.
                    r_wren    <= 1'b1;
                    r_wr_addr <= pack_addr(r_row, r_clr_col);
                    r_wr_char <= BLANK;
                    r_wr_colr <= io_bus.attr;
                    if (r_clr_col == COL_LAST) begin
                        r_clr_col <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_clr_col <= r_clr_col + 7'd1;
                    end
                end

                default: begin // IDLE
                    // in_ready rises one cycle after returning here, so it
                    // stays low through the cycle of the last clear write.
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        case (io_bus.in_data)
                            CC_CR: begin
                                r_col <= '0;
                            end

                            CC_BS: begin
                                if (r_col != 7'd0) begin
                                    r_col     <= r_col - 7'd1;
                                    r_wren    <= 1'b1;
                                    r_wr_addr <= pack_addr(r_row, r_col - 7'd1);
                                    r_wr_char <= BLANK;
                                    r_wr_colr <= io_bus.attr;
                                end
                            end

                            CC_FF: begin
                                r_col      <= '0;
                                r_row      <= '0;
                                r_clr_col  <= '0;
                                r_clr_row  <= '0;
                                r_in_ready <= 1'b0;
                                r_state    <= CLR_ALL;
                            end

                            CC_LF: begin
                                // No character write is pending, so the
                                // first clear write goes out right away.
                                r_col      <= '0;
                                r_row      <= w_row_next;
                                r_in_ready <= 1'b0;
                                r_wren     <= 1'b1;
                                r_wr_addr  <= pack_addr(w_row_next, 7'd0);
                                r_wr_char  <= BLANK;
                                r_wr_colr  <= io_bus.attr;
                                r_clr_col  <= 7'd1;
                                if (COL_LAST != 7'd0) begin
                                    r_state <= CLR_ROW;
                                end
                            end

`ifdef TEXT_WRITER_TAB_EN
                            CC_TAB: begin
                                if (w_tab_wrap) begin
                                    // Same as LF: immediate first clear write.
                                    r_col      <= '0;
                                    r_row      <= w_row_next;
                                    r_in_ready <= 1'b0;
                                    r_wren     <= 1'b1;
                                    r_wr_addr  <= pack_addr(w_row_next, 7'd0);
                                    r_wr_char  <= BLANK;
                                    r_wr_colr  <= io_bus.attr;
                                    r_clr_col  <= 7'd1;
                                    if (COL_LAST != 7'd0) begin
                                        r_state <= CLR_ROW;
                                    end
                                end else begin
                                    r_col <= w_tab_col[6:0];
                                end
                            end
`endif

                            default: begin
                                r_wren    <= 1'b1;
                                r_wr_addr <= pack_addr(r_row, r_col);
                                r_wr_char <= io_bus.in_data;
                                r_wr_colr <= io_bus.attr;
                                if (r_col == COL_LAST) begin
                                    // Character write goes out now; the row
                                    // clear follows on the next cycle.
                                    r_col      <= '0;
                                    r_row      <= w_row_next;
                                    r_clr_col  <= '0;
                                    r_in_ready <= 1'b0;
                                    r_state    <= CLR_ROW;
                                end else begin
                                    r_col <= r_col + 7'd1;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign io_bus.in_ready = r_in_ready;
    assign io_bus.wr_addr  = r_wr_addr;
    assign io_bus.wr_char  = r_wr_char;
    assign io_bus.wr_colr  = r_wr_colr;
    assign io_bus.wren_ms  = r_wren;
    assign io_bus.wren_mc  = r_wren;
    assign io_bus.cursor_x = r_col;
    assign io_bus.cursor_y = r_row;
    assign io_bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_text_writer.sv
// ----------------------------------------------------------------------------
// tb_text_writer
// Directed bench for text_writer: reset clear, printable writes, last-column
// wrap, LF wrap at the bottom row, BS, FF, reset during a row clear, and the
// TAB behaviour selected by TEXT_WRITER_TAB_EN.
// ----------------------------------------------------------------------------
module tb_text_writer;
    import text_pkg::*;

    logic clk = 1'b0;
    logic rst;

    text_writer_if bus_if ();

    text_writer dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Writes seen during the last run() call
    logic [11:0] q_addr[$];
    logic [7:0]  q_char[$];
    logic [7:0]  q_colr[$];
    int          q_cyc[$];
    int          stop_cyc;
    int          mc_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Optionally offer one byte, then clock until in_ready is high, logging
    // every write with the cycle index (1 = first cycle after the send edge).
    // With hold set, a dummy byte stays offered while in_ready is low.
    task automatic run(input bit do_send, input logic [7:0] b, input int limit, input bit hold = 1'b0);
        q_addr.delete(); q_char.delete(); q_colr.delete(); q_cyc.delete();
        stop_cyc = -1;
        mc_err   = 0;
        if (do_send) begin
            bus_if.in_data  = b;
            bus_if.in_valid = 1'b1;
        end
        for (int c = 1; c <= limit; c++) begin
            tick();
            bus_if.in_valid = 1'b0;
            if (bus_if.wren_mc !== bus_if.wren_ms) mc_err++;
            if (bus_if.wren_ms === 1'b1) begin
                q_addr.push_back(bus_if.wr_addr);
                q_char.push_back(bus_if.wr_char);
                q_colr.push_back(bus_if.wr_colr);
                q_cyc.push_back(c);
            end
            if (bus_if.in_ready === 1'b1) begin
                stop_cyc = c;
                break;
            end
            if (hold) begin
                bus_if.in_data  = 8'h51;
                bus_if.in_valid = 1'b1;
            end
        end
        bus_if.in_valid = 1'b0;
    endtask

    // Checks a block of consecutive blank writes that starts at column 0 of
    // start_row, after `skip` leading non-clear writes.
    task automatic chk_block(input string tag, input int skip, input int exp_n, input int exp_first,
                             input int start_row, input logic [7:0] exp_colr, input int exp_stop);
        int errs;
        int idx;
        logic [4:0] er;
        logic [6:0] ec;
        errs = 0;
        chk({tag, "_count"}, 32'(q_addr.size()), 32'(skip + exp_n));
        chk({tag, "_ready_cycle"}, 32'(stop_cyc), 32'(exp_stop));
        for (int k = 0; k < exp_n; k++) begin
            idx = skip + k;
            er  = 5'((start_row + k / 80) % 32);
            ec  = 7'(k % 80);
            if (idx >= q_addr.size()) errs++;
            else if (q_addr[idx] !== {er, ec} || q_char[idx] !== 8'h20 ||
                     q_colr[idx] !== exp_colr || q_cyc[idx] != exp_first + k) errs++;
        end
        chk({tag, "_content_errs"}, 32'(errs), 32'd0);
        chk({tag, "_wren_mc_diff"}, 32'(mc_err), 32'd0);
    endtask

    task automatic chk_cursor(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(bus_if.cursor_x), 32'(x));
        chk({tag, "_y"}, 32'(bus_if.cursor_y), 32'(y));
    endtask

    initial begin
        rst             = 1'b1;
        bus_if.in_data  = 8'h00;
        bus_if.in_valid = 1'b0;
        bus_if.attr     = 8'h07;

        // ---- 1: reset state and power-up clear ----
        repeat (3) tick();
        chk("rst_wren_ms", 32'(bus_if.wren_ms), 32'd0);
        chk("rst_wren_mc", 32'(bus_if.wren_mc), 32'd0);
        chk("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd1);
        chk("rst_wr_addr", 32'(bus_if.wr_addr), 32'd0);
        chk("rst_wr_char", 32'(bus_if.wr_char), 32'd0);
        chk_cursor("rst_cursor", 0, 0);
        rst = 1'b0;
        run(1'b0, 8'h00, 2100);
        chk_block("clr_all", 0, 2000, 1, 0, 8'h07, 2001);
        chk("clr_all_busy", 32'(bus_if.busy), 32'd0);
        chk_cursor("clr_all_cursor", 0, 0);
        $display("txn power-up clear: %0d writes, in_ready at cycle %0d", q_addr.size(), stop_cyc);

        // ---- 2: "AB" back-to-back ----
        bus_if.attr     = 8'h1F;
        bus_if.in_data  = 8'h41;
        bus_if.in_valid = 1'b1;
        tick();
        chk("A_wren", 32'(bus_if.wren_ms), 32'd1);
        chk("A_addr", 32'(bus_if.wr_addr), 32'h000);
        chk("A_char", 32'(bus_if.wr_char), 32'h41);
        chk("A_colr", 32'(bus_if.wr_colr), 32'h1F);
        chk("A_cursor_x", 32'(bus_if.cursor_x), 32'd1);
        bus_if.in_data = 8'h42;
        tick();
        bus_if.in_valid = 1'b0;
        chk("B_wren", 32'(bus_if.wren_ms), 32'd1);
        chk("B_addr", 32'(bus_if.wr_addr), 32'h001);
        chk("B_char", 32'(bus_if.wr_char), 32'h42);
        chk("B_colr", 32'(bus_if.wr_colr), 32'h1F);
        chk("B_cursor_x", 32'(bus_if.cursor_x), 32'd2);
        tick();
        chk("AB_idle_wren", 32'(bus_if.wren_ms), 32'd0);
        chk("AB_idle_ready", 32'(bus_if.in_ready), 32'd1);
        $display("txn AB: cursor_x=%0d", bus_if.cursor_x);

        // ---- 3: printable at last column of row 3 ----
        run(1'b1, CC_CR, 10);
        chk("cr_writes", 32'(q_addr.size()), 32'd0);
        chk_cursor("cr_cursor", 0, 0);
        repeat (3) run(1'b1, CC_LF, 200);
        repeat (79) run(1'b1, 8'h78, 10);
        chk_cursor("pre_Z_cursor", 79, 3);
        run(1'b1, 8'h5A, 200, 1'b1);
        chk("Z_addr", 32'(q_addr.size() > 0 ? q_addr[0] : 12'hFFF), 32'h1CF);
        chk("Z_char", 32'(q_char.size() > 0 ? q_char[0] : 8'h00), 32'h5A);
        chk("Z_cycle", 32'(q_cyc.size() > 0 ? q_cyc[0] : 0), 32'd1);
        chk_block("row4", 1, 80, 2, 4, 8'h1F, 82);
        chk_cursor("Z_cursor", 0, 4);
        $display("txn Z@(79,3): %0d writes, in_ready at cycle %0d", q_addr.size(), stop_cyc);

        // ---- 4: LF on the bottom row wraps to row 0; BS at column 0 ----
        repeat (20) run(1'b1, CC_LF, 200);
        repeat (5) run(1'b1, 8'h79, 10);
        chk_cursor("pre_lf_cursor", 5, 24);
        bus_if.attr = 8'h2E;
        run(1'b1, CC_LF, 200);
        chk_block("row0_wrap", 0, 80, 1, 0, 8'h2E, 81);
        chk_cursor("lf_wrap_cursor", 0, 0);
        $display("txn LF@(5,24): %0d writes, in_ready at cycle %0d", q_addr.size(), stop_cyc);
        run(1'b1, CC_BS, 10);
        chk("bs0_writes", 32'(q_addr.size()), 32'd0);
        chk("bs0_ready_cycle", 32'(stop_cyc), 32'd1);
        chk_cursor("bs0_cursor", 0, 0);
        $display("txn BS@(0,0): %0d writes", q_addr.size());

        // ---- 5: BS mid-row, then FF ----
        repeat (2) run(1'b1, CC_LF, 200);
        repeat (10) run(1'b1, 8'h6B, 10);
        bus_if.attr = 8'h4C;
        run(1'b1, CC_BS, 10);
        chk("bs_count", 32'(q_addr.size()), 32'd1);
        chk("bs_addr", 32'(q_addr.size() > 0 ? q_addr[0] : 12'hFFF), 32'h109);
        chk("bs_char", 32'(q_char.size() > 0 ? q_char[0] : 8'h00), 32'h20);
        chk("bs_colr", 32'(q_colr.size() > 0 ? q_colr[0] : 8'h00), 32'h4C);
        chk_cursor("bs_cursor", 9, 2);
        $display("txn BS@(10,2): %0d writes", q_addr.size());
        run(1'b1, CC_FF, 2200);
        chk_block("ff_clear", 0, 2000, 2, 0, 8'h4C, 2002);
        chk_cursor("ff_cursor", 0, 0);
        $display("txn FF: %0d writes, in_ready at cycle %0d", q_addr.size(), stop_cyc);

        // ---- TAB handling ----
`ifdef TEXT_WRITER_TAB_EN
        repeat (77) run(1'b1, 8'h74, 10);
        bus_if.attr = 8'h5A;
        run(1'b1, CC_TAB, 200);
        chk_block("tab_wrap", 0, 80, 1, 1, 8'h5A, 81);
        chk_cursor("tab_wrap_cursor", 0, 1);
        repeat (3) run(1'b1, 8'h61, 10);
        run(1'b1, CC_TAB, 10);
        chk("tab_writes", 32'(q_addr.size()), 32'd0);
        chk_cursor("tab_cursor", 8, 1);
        $display("txn TAB: cursor=(%0d,%0d)", bus_if.cursor_x, bus_if.cursor_y);
`else
        run(1'b1, CC_TAB, 10);
        chk("tab_count", 32'(q_addr.size()), 32'd1);
        chk("tab_addr", 32'(q_addr.size() > 0 ? q_addr[0] : 12'hFFF), 32'h000);
        chk("tab_char", 32'(q_char.size() > 0 ? q_char[0] : 8'h00), 32'h09);
        chk_cursor("tab_cursor", 1, 0);
        $display("txn TAB as printable: cursor=(%0d,%0d)", bus_if.cursor_x, bus_if.cursor_y);
`endif

        // ---- 6: reset during a row clear ----
        bus_if.attr     = 8'h33;
        bus_if.in_data  = CC_LF;
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        repeat (9) tick();
        chk("mid_clr_busy", 32'(bus_if.busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_wren_ms", 32'(bus_if.wren_ms), 32'd0);
        chk("mid_rst_wren_mc", 32'(bus_if.wren_mc), 32'd0);
        chk("mid_rst_ready", 32'(bus_if.in_ready), 32'd0);
        chk_cursor("mid_rst_cursor", 0, 0);
        rst = 1'b0;
        run(1'b0, 8'h00, 2100);
        chk_block("rst_clr_all", 0, 2000, 1, 0, 8'h33, 2001);
        $display("txn reset mid-clear: %0d writes, in_ready at cycle %0d", q_addr.size(), stop_cyc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
